// File: rtl/pipe_pkg.sv
// EX->MEM pipeline register field layouts shared by the skid-buffered stage cascade.
package pipe_pkg;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 101;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } exmem_data_t;
endpackage

// File: rtl/pipe_skid_slot.sv
// One register slot: main entry drives the output, skid entry absorbs the single
// in-flight beat that arrives after downstream stalls; ready is !skid_vld (registered).
module pipe_skid_slot #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);
  logic              main_vld, skid_vld;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_ctrl  = main_vld ? main_ctrl : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // payload is left as-is; only the fields that can cause side effects are squashed
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (!main_vld || out_ready) begin
      if (skid_vld) begin
        main_vld  <= 1'b1;
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_vld  <= 1'b0;
        skid_ctrl <= '0;
      end else if (in_valid) begin
        main_vld  <= 1'b1;
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else begin
        main_vld  <= 1'b0;
        main_ctrl <= '0;
      end
    end else if (in_valid && !skid_vld) begin
      skid_vld  <= 1'b1;
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// Cascade of STAGES skid slots with flush and bubble squashing.
// Optional PIPE_STAGE_SKID_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_SKID_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipe_stage_skid: STAGES=%0d outside 1..8", STAGES);
  end

  // index 0 is the upstream port, index STAGES the downstream port
  logic [STAGES:0]             vld_pipe, rdy_pipe;
  logic [STAGES:0][CTRL_W-1:0] ctrl_pipe;
  logic [STAGES:0][DATA_W-1:0] data_pipe;

  assign vld_pipe[0]      = in_valid;
  assign ctrl_pipe[0]     = in_ctrl;
  assign data_pipe[0]     = in_data;
  assign in_ready         = rdy_pipe[0];
  assign rdy_pipe[STAGES] = out_ready;
  assign out_valid        = vld_pipe[STAGES];
  assign out_ctrl         = ctrl_pipe[STAGES];
  assign out_data         = data_pipe[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (vld_pipe[g]),
      .in_ready (rdy_pipe[g]),
      .in_ctrl  (ctrl_pipe[g]),
      .in_data  (data_pipe[g]),
      .out_valid(vld_pipe[g+1]),
      .out_ready(rdy_pipe[g+1]),
      .out_ctrl (ctrl_pipe[g+1]),
      .out_data (data_pipe[g+1])
    );
  end

`ifdef PIPE_STAGE_SKID_STATS_EN
  // a slot's skid is only ever occupied behind a valid main, so main valids suffice
  logic any_held;
  assign any_held = (vld_pipe >> 1) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && any_held && flush_cnt != '1)        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + scoreboarded checks of pipe_stage_skid at STAGES=1 and STAGES=3.
module tb_pipe_stage_skid;
  localparam int CW = 4;
  localparam int DW = 101;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic          fl1 = 0, iv1 = 0, ir1, ov1, or1 = 0;
  logic [CW-1:0] ic1 = '0, oc1;
  logic [DW-1:0] id1 = '0, od1;
  logic          fl3 = 0, iv3 = 0, ir3, ov3, or3 = 0;
  logic [CW-1:0] ic3 = '0, oc3;
  logic [DW-1:0] id3 = '0, od3;
`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [31:0] st1, st3;
  logic [15:0] fc1, fc3;
`endif

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1)
`ifdef PIPE_STAGE_SKID_STATS_EN
    , .stall_cnt(st1), .flush_cnt(fc1)
`endif
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .STAGES(3)) u_s3 (
    .clk(clk), .reset(reset), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
    .in_ctrl(ic3), .in_data(id3), .out_valid(ov3), .out_ready(or3),
    .out_ctrl(oc3), .out_data(od3)
`ifdef PIPE_STAGE_SKID_STATS_EN
    , .stall_cnt(st3), .flush_cnt(fc3)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // push into the 3-stage pipe with out_ready low until it refuses
  task automatic fill3(output int n);
    n   = 0;
    or3 = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (!ir3) break;
      iv3 = 1'b1;
      id3 = DW'(n + 1);
      ic3 = 4'hF;
      n++;
    end
    iv3 = 1'b0;
  endtask

  initial begin
    int n, got, cnt, sent, recv, oerr, berr, ex;
    int q[$];

    do_reset();
    chk("rst_in_ready", ir1, 1);
    chk("rst_out_valid", ov1, 0);
    chk("rst_out_ctrl", oc1, 0);
    chk("rst_out_data", od1, 0);
    chk("rst3_in_ready", ir3, 1);

    // STAGES=1 streaming, one per cycle, one-cycle latency
    or1 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      chk("s1_in_ready", ir1, 1);
      if (i > 1) begin
        chk("s1_valid", ov1, 1);
        chk("s1_data", od1, 128'(i - 1));
        chk("s1_ctrl", oc1, 4'hF);
      end
      if (i <= 16) begin
        iv1 = 1'b1;
        id1 = DW'(i);
        ic1 = 4'hF;
      end else iv1 = 1'b0;
    end
    @(negedge clk);
    chk("s1_idle_valid", ov1, 0);
    chk("s1_idle_ctrl", oc1, 0);

    // STAGES=3 capacity and in-order drain
    fill3(n);
    chk("s3_fill_cnt", 128'(n), 6);
    chk("s3_full_valid", ov3, 1);
    chk("s3_full_head", od3, 1);
    or3 = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (ov3) begin
        chk("s3_drain_data", od3, 128'(got + 1));
        got++;
      end
      @(negedge clk);
    end
    chk("s3_drain_cnt", 128'(got), 6);

    // random traffic against a scoreboard
    sent = 0; recv = 0; oerr = 0; berr = 0;
    for (int c = 0; c < 60000 && recv < 10000; c++) begin
      @(negedge clk);
      if (!ov3 && oc3 != '0) berr++;
      iv3 = (sent < 10000) && ($urandom_range(0, 1) == 1);
      or3 = ($urandom_range(0, 1) == 1);
      if (iv3 && ir3) begin
        id3 = DW'(sent + 1);
        ic3 = CW'(sent + 1) | 4'h1;
        q.push_back(sent + 1);
        sent++;
      end
      if (ov3 && or3) begin
        if (q.size() == 0) oerr++;
        else begin
          ex = q.pop_front();
          if (od3 != DW'(ex) || oc3 != (CW'(ex) | 4'h1)) oerr++;
        end
        recv++;
      end
    end
    iv3 = 1'b0;
    chk("rand_recv", 128'(recv), 10000);
    chk("rand_order_err", 128'(oerr), 0);
    chk("rand_bubble_ctrl", 128'(berr), 0);
    chk("rand_left", 128'(q.size()), 0);

    // flush a full pipe, then flush an accepted beat
    @(negedge clk);
    fill3(n);
    chk("fl_fill_cnt", 128'(n), 6);
    iv3 = 1'b1; id3 = DW'(32'h99); ic3 = 4'hF; fl3 = 1'b1;
    @(negedge clk);
    fl3 = 1'b0; iv3 = 1'b0;
    chk("fl_out_valid", ov3, 0);
    chk("fl_out_ctrl", oc3, 0);
    chk("fl_in_ready", ir3, 1);
    iv3 = 1'b1; id3 = DW'(32'h77); fl3 = 1'b1;
    @(negedge clk);
    fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov3) cnt++;
    end
    chk("fl_leak", 128'(cnt), 0);
    iv3 = 1'b1; id3 = DW'(32'h55); ic3 = 4'h3;
    @(negedge clk);
    iv3 = 1'b0;
    @(negedge clk);
    chk("s3_lat_early", ov3, 0);
    @(negedge clk);
    chk("s3_lat_valid", ov3, 1);
    chk("s3_lat_data", od3, 32'h55);
    chk("s3_lat_ctrl", oc3, 4'h3);

    // reset while the STAGES=1 skid is occupied
    or1 = 1'b0;
    iv1 = 1'b1; id1 = DW'(32'h11); ic1 = 4'hF;
    @(negedge clk);
    id1 = DW'(32'h12);
    @(negedge clk);
    iv1 = 1'b0;
    chk("rs_skid_full", ir1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_valid", ov1, 0);
    chk("rs_ctrl", oc1, 0);
    chk("rs_data", od1, 0);
    chk("rs_in_ready", ir1, 1);
    iv1 = 1'b1; id1 = DW'(32'hAB); ic1 = 4'h9; or1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    chk("rs_ab_valid", ov1, 1);
    chk("rs_ab_data", od1, 32'hAB);
    chk("rs_ab_ctrl", oc1, 4'h9);
    @(negedge clk);
    chk("rs_no_residue", ov1, 0);

`ifdef PIPE_STAGE_SKID_STATS_EN
    do_reset();
    chk("st_rst_stall", st1, 0);
    chk("st_rst_flush", fc1, 0);
    or1 = 1'b0;
    iv1 = 1'b1; id1 = DW'(5); ic1 = 4'hF;
    @(negedge clk);
    iv1 = 1'b0;
    repeat (7) @(negedge clk);
    or1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b1; id1 = DW'(6);
    @(negedge clk);
    iv1 = 1'b0; fl1 = 1'b1;
    @(negedge clk);
    fl1 = 1'b1;
    @(negedge clk);
    fl1 = 1'b0;
    @(negedge clk);
    chk("st_stall_cnt", st1, 7);
    chk("st_flush_cnt", fc1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
